// File: rtl/datapath_execute.sv
// Execute stage of the 16-bit, 8-register pipelined CPU.
// Computes ALU results and N/Z flags, resolves branches/jumps, drives the data-memory strobes,
// and registers the writeback information into the EX/WB pipeline register.
// Optional feature: define BYPASS_EN to forward writeback data onto the Rx/Ry operands.
module datapath_execute #(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_valid,
  input  logic [DW-1:0] i_instr,
  input  logic [DW-1:0] i_pc,
  input  logic [DW-1:0] i_rx_data,
  input  logic [DW-1:0] i_ry_data,
  input  logic          i_stall,
  input  logic          i_wb_en,
  input  logic [RW-1:0] i_wb_reg,
  input  logic [DW-1:0] i_wb_data,
  output logic [DW-1:0] o_BT,
  output logic          o_PCsrc,
  output logic [DW-1:0] o_ldst_addr,
  output logic          o_ldst_rd,
  output logic          o_ldst_wr,
  output logic [DW-1:0] o_ldst_wrdata,
  output logic          o_valid,
  output logic          o_wr_en,
  output logic [RW-1:0] o_wr_reg,
  output logic [DW-1:0] o_result,
  output logic          o_is_load,
  output logic [1:0]    o_flags
);

  localparam logic [4:0] OpMv   = 5'b00000;
  localparam logic [4:0] OpAdd  = 5'b00001;
  localparam logic [4:0] OpSub  = 5'b00010;
  localparam logic [4:0] OpCmp  = 5'b00011;
  localparam logic [4:0] OpLd   = 5'b00100;
  localparam logic [4:0] OpSt   = 5'b00101;
  localparam logic [4:0] OpJr   = 5'b01000;
  localparam logic [4:0] OpJzr  = 5'b01001;
  localparam logic [4:0] OpJnr  = 5'b01010;
  localparam logic [4:0] OpCallr = 5'b01100;
  localparam logic [4:0] OpMvi  = 5'b10000;
  localparam logic [4:0] OpAddi = 5'b10001;
  localparam logic [4:0] OpSubi = 5'b10010;
  localparam logic [4:0] OpCmpi = 5'b10011;
  localparam logic [4:0] OpMvhi = 5'b10110;
  localparam logic [4:0] OpJ    = 5'b11000;
  localparam logic [4:0] OpJz   = 5'b11001;
  localparam logic [4:0] OpJn   = 5'b11010;
  localparam logic [4:0] OpCall = 5'b11100;

  localparam logic [RW-1:0] LinkReg = {RW{1'b1}};

  logic [4:0]    opcode;
  logic [RW-1:0] rx_idx;
  logic [RW-1:0] ry_idx;
  logic [DW-1:0] imm8;
  logic [DW-1:0] imm11;
  logic [DW-1:0] rx_op;
  logic [DW-1:0] ry_op;
  logic          active;

  // Decoded next-state / combinational results
  logic [DW-1:0] res_d;
  logic          wr_en_d;
  logic [RW-1:0] wr_reg_d;
  logic          is_load_d;
  logic          set_flags;
  logic          taken;
  logic [DW-1:0] target;
  logic          is_ld;
  logic          is_st;

  // EX/WB register
  logic          valid_q;
  logic          wr_en_q;
  logic [RW-1:0] wr_reg_q;
  logic [DW-1:0] result_q;
  logic          is_load_q;
  logic [1:0]    flags_q;

  assign opcode = i_instr[4:0];
  assign rx_idx = i_instr[7:5];
  assign ry_idx = i_instr[10:8];
  assign imm8   = {{(DW-8){i_instr[15]}}, i_instr[15:8]};
  assign imm11  = {{(DW-12){i_instr[15]}}, i_instr[15:5], 1'b0};
  assign active = i_valid & ~i_stall;

`ifdef BYPASS_EN
  // Forward the value being written back this cycle onto each source independently
  always_comb begin
    rx_op = i_rx_data;
    ry_op = i_ry_data;
    if (i_wb_en && (i_wb_reg == rx_idx)) rx_op = i_wb_data;
    if (i_wb_en && (i_wb_reg == ry_idx)) ry_op = i_wb_data;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{i_wb_en, i_wb_reg, i_wb_data};
  assign rx_op = i_rx_data;
  assign ry_op = i_ry_data;
`endif

  // Instruction decode: ALU result, writeback control, branch resolution, memory ops
  always_comb begin
    res_d     = '0;
    wr_en_d   = 1'b0;
    wr_reg_d  = rx_idx;
    is_load_d = 1'b0;
    set_flags = 1'b0;
    taken     = 1'b0;
    target    = rx_op;
    is_ld     = 1'b0;
    is_st     = 1'b0;
    case (opcode)
      OpMv:   begin res_d = ry_op;         wr_en_d = 1'b1; end
      OpMvi:  begin res_d = imm8;          wr_en_d = 1'b1; end
      OpAdd:  begin res_d = rx_op + ry_op; wr_en_d = 1'b1; set_flags = 1'b1; end
      OpAddi: begin res_d = rx_op + imm8;  wr_en_d = 1'b1; set_flags = 1'b1; end
      OpSub:  begin res_d = rx_op - ry_op; wr_en_d = 1'b1; set_flags = 1'b1; end
      OpSubi: begin res_d = rx_op - imm8;  wr_en_d = 1'b1; set_flags = 1'b1; end
      OpCmp:  begin res_d = rx_op - ry_op; set_flags = 1'b1; end
      OpCmpi: begin res_d = rx_op - imm8;  set_flags = 1'b1; end
      OpMvhi: begin res_d = {i_instr[15:8], rx_op[7:0]}; wr_en_d = 1'b1; end
      OpLd:   begin is_ld = 1'b1; wr_en_d = 1'b1; is_load_d = 1'b1; end
      OpSt:   begin is_st = 1'b1; end
      OpJr:   begin taken = 1'b1; end
      OpJzr:  begin taken = flags_q[0]; end
      OpJnr:  begin taken = flags_q[1]; end
      OpCallr: begin
        taken    = 1'b1;
        res_d    = i_pc;
        wr_en_d  = 1'b1;
        wr_reg_d = LinkReg;
      end
      OpJ:    begin taken = 1'b1;       target = i_pc + imm11; end
      OpJz:   begin taken = flags_q[0]; target = i_pc + imm11; end
      OpJn:   begin taken = flags_q[1]; target = i_pc + imm11; end
      OpCall: begin
        taken    = 1'b1;
        target   = i_pc + imm11;
        res_d    = i_pc;
        wr_en_d  = 1'b1;
        wr_reg_d = LinkReg;
      end
      default: ;
    endcase
  end

  // Combinational branch and memory outputs; forced low while reset is asserted
  always_comb begin
    o_PCsrc       = reset & active & taken;
    o_BT          = reset ? target : '0;
    o_ldst_rd     = reset & active & is_ld;
    o_ldst_wr     = reset & active & is_st;
    o_ldst_addr   = reset ? ry_op : '0;
    o_ldst_wrdata = reset ? rx_op : '0;
  end

  // EX/WB pipeline register and flags; both hold while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      result_q  <= '0;
      is_load_q <= 1'b0;
      flags_q   <= 2'b00;
    end else if (!i_stall) begin
      valid_q   <= i_valid;
      wr_en_q   <= i_valid & wr_en_d;
      wr_reg_q  <= wr_reg_d;
      result_q  <= res_d;
      is_load_q <= i_valid & is_load_d;
      if (i_valid && set_flags) flags_q <= {res_d[DW-1], (res_d == '0)};
    end
  end

  assign o_valid   = valid_q;
  assign o_wr_en   = wr_en_q;
  assign o_wr_reg  = wr_reg_q;
  assign o_result  = result_q;
  assign o_is_load = is_load_q;
  assign o_flags   = flags_q;

endmodule
